decode_stage_buf: RTL and testbench

// Registered RV32I decode stage between InstQueue and Dispatcher.

---
 rtl/decode_stage_buf.sv | 266 ++++++++++++++++++++++++++
 tb/tb_decode_stage_buf.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_buf.sv
// RV32I decode stage: decodes each instruction accepted from the InstQueue, tags it with its PC
// and queues the record in a small FIFO toward the Dispatcher, with flush for mispredict recovery.
`ifndef OP_TYPE_WIDTH
`define OP_TYPE_WIDTH 3
`endif
`ifndef OP_WIDTH
`define OP_WIDTH 6
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 5
`endif

module decode_stage_buf #(
  parameter int DEPTH    = 2,
  parameter int PC_WIDTH = 32
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       flush_in,
  input  logic                       iq_valid_in,
  output logic                       iq_ready_out,
  input  logic [31:0]                inst_iq_in,
  input  logic [PC_WIDTH-1:0]        pc_iq_in,
  output logic                       dp_valid_out,
  input  logic                       dp_ready_in,
  output logic [`OP_TYPE_WIDTH-1:0]  op_type_dp_out,
  output logic [`OP_WIDTH-1:0]       opcode_dp_out,
  output logic [`REG_WIDTH-1:0]      rs1_dp_out,
  output logic [`REG_WIDTH-1:0]      rs2_dp_out,
  output logic [`REG_WIDTH-1:0]      rd_dp_out,
  output logic [31:0]                imm_dp_out,
  output logic [PC_WIDTH-1:0]        pc_dp_out,
  output logic                       illegal_dp_out,
  output logic [$clog2(DEPTH):0]     count_out
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [`OP_TYPE_WIDTH-1:0] OPT_NOP = 3'd0, OPT_ARITH = 3'd1, OPT_BRANCH = 3'd2,
                                        OPT_LOAD = 3'd3, OPT_STORE = 3'd4;
  localparam logic [`OP_WIDTH-1:0]
    OP_NOP = 6'd0, OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3, OP_JALR = 6'd4,
    OP_BEQ = 6'd5, OP_BNE = 6'd6, OP_BLT = 6'd7, OP_BGE = 6'd8, OP_BLTU = 6'd9, OP_BGEU = 6'd10,
    OP_LB = 6'd11, OP_LH = 6'd12, OP_LW = 6'd13, OP_LBU = 6'd14, OP_LHU = 6'd15,
    OP_SB = 6'd16, OP_SH = 6'd17, OP_SW = 6'd18,
    OP_ADDI = 6'd19, OP_SLTI = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22, OP_ORI = 6'd23,
    OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI = 6'd26, OP_SRAI = 6'd27,
    OP_ADD = 6'd28, OP_SUB = 6'd29, OP_SLL = 6'd30, OP_SLT = 6'd31, OP_SLTU = 6'd32,
    OP_XOR = 6'd33, OP_SRL = 6'd34, OP_SRA = 6'd35, OP_OR = 6'd36, OP_AND = 6'd37;

  typedef struct packed {
    logic [`OP_TYPE_WIDTH-1:0] op_type;
    logic [`OP_WIDTH-1:0]      opcode;
    logic [`REG_WIDTH-1:0]     rs1;
    logic [`REG_WIDTH-1:0]     rs2;
    logic [`REG_WIDTH-1:0]     rd;
    logic [31:0]               imm;
    logic [PC_WIDTH-1:0]       pc;
    logic                      illegal;
  } rec_t;

  rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_s, pop_s;

  logic [6:0]  opc_s, f7_s;
  logic [2:0]  f3_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [`OP_TYPE_WIDTH-1:0] dec_type_s;
  logic [`OP_WIDTH-1:0]      dec_op_s;
  logic [`REG_WIDTH-1:0]     dec_rs1_s, dec_rs2_s, dec_rd_s;
  logic [31:0]               dec_imm_s;
  logic                      dec_bad_s;
  rec_t                      dec_s, head_s;

  assign opc_s   = inst_iq_in[6:0];
  assign f3_s    = inst_iq_in[14:12];
  assign f7_s    = inst_iq_in[31:25];
  assign imm_i_s = {{20{inst_iq_in[31]}}, inst_iq_in[31:20]};
  assign imm_s_s = {{20{inst_iq_in[31]}}, inst_iq_in[31:25], inst_iq_in[11:7]};
  assign imm_b_s = {{19{inst_iq_in[31]}}, inst_iq_in[31], inst_iq_in[7], inst_iq_in[30:25],
                    inst_iq_in[11:8], 1'b0};
  assign imm_u_s = {inst_iq_in[31:12], 12'h000};
  assign imm_j_s = {{11{inst_iq_in[31]}}, inst_iq_in[31], inst_iq_in[19:12], inst_iq_in[20],
                    inst_iq_in[30:21], 1'b0};

  // Instruction decode into a record; illegal encodings collapse to a NOP that keeps its PC
  always_comb begin
    dec_type_s = OPT_NOP;
    dec_op_s   = OP_NOP;
    dec_rs1_s  = 5'd0;
    dec_rs2_s  = 5'd0;
    dec_rd_s   = 5'd0;
    dec_imm_s  = 32'd0;
    dec_bad_s  = 1'b0;
    case (opc_s)
      7'b0110111: begin dec_type_s = OPT_ARITH; dec_op_s = OP_LUI; dec_rd_s = inst_iq_in[11:7]; dec_imm_s = imm_u_s; end
      7'b0010111: begin dec_type_s = OPT_ARITH; dec_op_s = OP_AUIPC; dec_rd_s = inst_iq_in[11:7]; dec_imm_s = imm_u_s; end
      7'b1101111: begin dec_type_s = OPT_BRANCH; dec_op_s = OP_JAL; dec_rd_s = inst_iq_in[11:7]; dec_imm_s = imm_j_s; end
      7'b1100111: begin
        dec_type_s = OPT_BRANCH; dec_op_s = OP_JALR; dec_imm_s = imm_i_s;
        dec_rs1_s  = inst_iq_in[19:15]; dec_rd_s = inst_iq_in[11:7];
        dec_bad_s  = (f3_s != 3'b000);
      end
      7'b1100011: begin
        dec_type_s = OPT_BRANCH; dec_imm_s = imm_b_s;
        dec_rs1_s  = inst_iq_in[19:15]; dec_rs2_s = inst_iq_in[24:20];
        case (f3_s)
          3'b000:  dec_op_s = OP_BEQ;
          3'b001:  dec_op_s = OP_BNE;
          3'b100:  dec_op_s = OP_BLT;
          3'b101:  dec_op_s = OP_BGE;
          3'b110:  dec_op_s = OP_BLTU;
          3'b111:  dec_op_s = OP_BGEU;
          default: dec_bad_s = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec_type_s = OPT_LOAD; dec_imm_s = imm_i_s;
        dec_rs1_s  = inst_iq_in[19:15]; dec_rd_s = inst_iq_in[11:7];
        case (f3_s)
          3'b000:  dec_op_s = OP_LB;
          3'b001:  dec_op_s = OP_LH;
          3'b010:  dec_op_s = OP_LW;
          3'b100:  dec_op_s = OP_LBU;
          3'b101:  dec_op_s = OP_LHU;
          default: dec_bad_s = 1'b1;
        endcase
      end
      7'b0100011: begin
        dec_type_s = OPT_STORE; dec_imm_s = imm_s_s;
        dec_rs1_s  = inst_iq_in[19:15]; dec_rs2_s = inst_iq_in[24:20];
        case (f3_s)
          3'b000:  dec_op_s = OP_SB;
          3'b001:  dec_op_s = OP_SH;
          3'b010:  dec_op_s = OP_SW;
          default: dec_bad_s = 1'b1;
        endcase
      end
      7'b0010011: begin
        dec_type_s = OPT_ARITH; dec_imm_s = imm_i_s;
        dec_rs1_s  = inst_iq_in[19:15]; dec_rd_s = inst_iq_in[11:7];
        case (f3_s)
          3'b000:  dec_op_s = OP_ADDI;
          3'b010:  dec_op_s = OP_SLTI;
          3'b011:  dec_op_s = OP_SLTIU;
          3'b100:  dec_op_s = OP_XORI;
          3'b110:  dec_op_s = OP_ORI;
          3'b111:  dec_op_s = OP_ANDI;
          3'b001: begin
            dec_op_s  = OP_SLLI;
            dec_imm_s = {27'd0, inst_iq_in[24:20]};
            dec_bad_s = (f7_s != 7'b0000000);
          end
          3'b101: begin
            dec_op_s  = inst_iq_in[30] ? OP_SRAI : OP_SRLI;
            dec_imm_s = {27'd0, inst_iq_in[24:20]};
          end
          default: dec_bad_s = 1'b1;
        endcase
      end
      7'b0110011: begin
        dec_type_s = OPT_ARITH;
        dec_rs1_s  = inst_iq_in[19:15]; dec_rs2_s = inst_iq_in[24:20]; dec_rd_s = inst_iq_in[11:7];
        if (f7_s == 7'b0000000) begin
          case (f3_s)
            3'b000:  dec_op_s = OP_ADD;
            3'b001:  dec_op_s = OP_SLL;
            3'b010:  dec_op_s = OP_SLT;
            3'b011:  dec_op_s = OP_SLTU;
            3'b100:  dec_op_s = OP_XOR;
            3'b101:  dec_op_s = OP_SRL;
            3'b110:  dec_op_s = OP_OR;
            default: dec_op_s = OP_AND;
          endcase
        end else if (f7_s == 7'b0100000 && f3_s == 3'b000) begin
          dec_op_s = OP_SUB;
        end else if (f7_s == 7'b0100000 && f3_s == 3'b101) begin
          dec_op_s = OP_SRA;
        end else begin
          dec_bad_s = 1'b1;
        end
      end
      default: dec_bad_s = 1'b1;
    endcase

    dec_s.pc      = pc_iq_in;
    dec_s.illegal = dec_bad_s;
    if (dec_bad_s) begin
      dec_s.op_type = OPT_NOP;
      dec_s.opcode  = OP_NOP;
      dec_s.rs1     = 5'd0;
      dec_s.rs2     = 5'd0;
      dec_s.rd      = 5'd0;
      dec_s.imm     = 32'd0;
    end else begin
      dec_s.op_type = dec_type_s;
      dec_s.opcode  = dec_op_s;
      dec_s.rs1     = dec_rs1_s;
      dec_s.rs2     = dec_rs2_s;
      dec_s.rd      = dec_rd_s;
      dec_s.imm     = dec_imm_s;
    end
  end

  assign iq_ready_out = (count_q != CNT_W'(DEPTH)) && !flush_in;
  assign dp_valid_out = (count_q != {CNT_W{1'b0}});
  assign push_s       = iq_valid_in & iq_ready_out & rdy_in;
  assign pop_s        = dp_valid_out & dp_ready_in & rdy_in;

  // Pointer/occupancy next state; flush outranks push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (rdy_in && flush_in) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = {CNT_W{1'b0}};
    end else begin
      wr_ptr_d = push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop_s  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and record storage registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_s) mem_q[wr_ptr_q] <= dec_s;
    end
  end

  // Head record, forced to an all-zero NOP while empty
  always_comb begin
    if (dp_valid_out) begin
      head_s = mem_q[rd_ptr_q];
    end else begin
      head_s = '0;
    end
  end

  assign op_type_dp_out = head_s.op_type;
  assign opcode_dp_out  = head_s.opcode;
  assign rs1_dp_out     = head_s.rs1;
  assign rs2_dp_out     = head_s.rs2;
  assign rd_dp_out      = head_s.rd;
  assign imm_dp_out     = head_s.imm;
  assign pc_dp_out      = head_s.pc;
  assign illegal_dp_out = head_s.illegal;
  assign count_out      = count_q;
endmodule

// File: tb/tb_decode_stage_buf.sv
// Bench for decode_stage_buf: directed vector table, hand-written FIFO corner sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_decode_stage_buf;
  localparam int DEPTH = 2;

  localparam int OPC_NOP=0, OPC_LUI=1, OPC_AUIPC=2, OPC_JAL=3, OPC_JALR=4, OPC_BEQ=5, OPC_BNE=6,
    OPC_BLT=7, OPC_BGE=8, OPC_BLTU=9, OPC_BGEU=10, OPC_LB=11, OPC_LH=12, OPC_LW=13, OPC_LBU=14,
    OPC_LHU=15, OPC_SB=16, OPC_SH=17, OPC_SW=18, OPC_ADDI=19, OPC_SLTI=20, OPC_SLTIU=21,
    OPC_XORI=22, OPC_ORI=23, OPC_ANDI=24, OPC_SLLI=25, OPC_SRLI=26, OPC_SRAI=27, OPC_ADD=28,
    OPC_SUB=29, OPC_SLL=30, OPC_SLT=31, OPC_SLTU=32, OPC_XOR=33, OPC_SRL=34, OPC_SRA=35,
    OPC_OR=36, OPC_AND=37;
  localparam int T_NOP=0, T_ARITH=1, T_BRANCH=2, T_LOAD=3, T_STORE=4;

  // Mnemonic per funct3; 0 marks a reserved funct3
  localparam int BR_TAB  [8] = '{OPC_BEQ, OPC_BNE, 0, 0, OPC_BLT, OPC_BGE, OPC_BLTU, OPC_BGEU};
  localparam int LD_TAB  [8] = '{OPC_LB, OPC_LH, OPC_LW, 0, OPC_LBU, OPC_LHU, 0, 0};
  localparam int ST_TAB  [8] = '{OPC_SB, OPC_SH, OPC_SW, 0, 0, 0, 0, 0};
  localparam int IMM_TAB [8] = '{OPC_ADDI, OPC_SLLI, OPC_SLTI, OPC_SLTIU, OPC_XORI, OPC_SRLI, OPC_ORI, OPC_ANDI};
  localparam int OP_TAB  [8] = '{OPC_ADD, OPC_SLL, OPC_SLT, OPC_SLTU, OPC_XOR, OPC_SRL, OPC_OR, OPC_AND};

  typedef struct packed {
    logic [2:0]  op_type;
    logic [5:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        illegal;
  } rec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    rec_t        e;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, flush = 1'b0, iq_valid = 1'b0, dp_ready = 1'b0;
  logic [31:0] inst = 32'd0, pc = 32'd0;
  logic        iq_ready, dp_valid, illegal;
  logic [2:0]  op_type;
  logic [5:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, pc_o;
  logic [1:0]  count;

  int n_cmp = 0, n_bad = 0;
  rec_t model_q[$];
  vec_t vt[12];

  decode_stage_buf #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .flush_in(flush),
    .iq_valid_in(iq_valid), .iq_ready_out(iq_ready), .inst_iq_in(inst), .pc_iq_in(pc),
    .dp_valid_out(dp_valid), .dp_ready_in(dp_ready), .op_type_dp_out(op_type),
    .opcode_dp_out(opcode), .rs1_dp_out(rs1), .rs2_dp_out(rs2), .rd_dp_out(rd),
    .imm_dp_out(imm), .pc_dp_out(pc_o), .illegal_dp_out(illegal), .count_out(count));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_r(input string name, input rec_t exp);
    rec_t a;
    a.op_type = op_type; a.opcode = opcode; a.rs1 = rs1; a.rs2 = rs2; a.rd = rd;
    a.imm = imm; a.pc = pc_o; a.illegal = illegal;
    n_cmp++;
    if (a !== exp) begin
      n_bad++;
      $display("FAIL %s: got type=%0d op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h pc=%h ill=%b want type=%0d op=%0d rs1=%0d rs2=%0d rd=%0d imm=%h pc=%h ill=%b",
               name, a.op_type, a.opcode, a.rs1, a.rs2, a.rd, a.imm, a.pc, a.illegal,
               exp.op_type, exp.opcode, exp.rs1, exp.rs2, exp.rd, exp.imm, exp.pc, exp.illegal);
    end
  endtask

  function automatic rec_t mk(input int t, input int op, input int s1, input int s2, input int d,
                              input logic [31:0] im, input logic [31:0] p, input logic ill);
    rec_t r;
    r.op_type = 3'(t); r.opcode = 6'(op); r.rs1 = 5'(s1); r.rs2 = 5'(s2); r.rd = 5'(d);
    r.imm = im; r.pc = p; r.illegal = ill;
    return r;
  endfunction

  // Reference decoder: signed immediates via integer arithmetic, mnemonics via funct3 tables
  function automatic rec_t ref_decode(input logic [31:0] i, input logic [31:0] p);
    rec_t r;
    int ival, sval, bval, jval, code;
    bit bad;
    logic [2:0] f3;
    logic [6:0] f7;
    r = '0; bad = 0; code = 0;
    f3 = i[14:12]; f7 = i[31:25];
    ival = int'(i[31:20]);                                      if (ival >= 2048) ival -= 4096;
    sval = int'({i[31:25], i[11:7]});                           if (sval >= 2048) sval -= 4096;
    bval = 2 * int'({i[31], i[7], i[30:25], i[11:8]});          if (bval >= 4096) bval -= 8192;
    jval = 2 * int'({i[31], i[19:12], i[20], i[30:21]});        if (jval >= 1048576) jval -= 2097152;
    case (i[6:0])
      7'h37: begin code = OPC_LUI;   r.op_type = 3'(T_ARITH); r.rd = i[11:7]; r.imm = i & 32'hFFFFF000; end
      7'h17: begin code = OPC_AUIPC; r.op_type = 3'(T_ARITH); r.rd = i[11:7]; r.imm = i & 32'hFFFFF000; end
      7'h6F: begin code = OPC_JAL;   r.op_type = 3'(T_BRANCH); r.rd = i[11:7]; r.imm = 32'(jval); end
      7'h67: begin
        code = OPC_JALR; r.op_type = 3'(T_BRANCH); r.rs1 = i[19:15]; r.rd = i[11:7];
        r.imm = 32'(ival); bad = (f3 != 3'd0);
      end
      7'h63: begin
        code = BR_TAB[f3]; r.op_type = 3'(T_BRANCH); r.rs1 = i[19:15]; r.rs2 = i[24:20];
        r.imm = 32'(bval); bad = (code == 0);
      end
      7'h03: begin
        code = LD_TAB[f3]; r.op_type = 3'(T_LOAD); r.rs1 = i[19:15]; r.rd = i[11:7];
        r.imm = 32'(ival); bad = (code == 0);
      end
      7'h23: begin
        code = ST_TAB[f3]; r.op_type = 3'(T_STORE); r.rs1 = i[19:15]; r.rs2 = i[24:20];
        r.imm = 32'(sval); bad = (code == 0);
      end
      7'h13: begin
        code = IMM_TAB[f3]; r.op_type = 3'(T_ARITH); r.rs1 = i[19:15]; r.rd = i[11:7];
        r.imm = 32'(ival);
        if (f3 == 3'd1 || f3 == 3'd5) r.imm = 32'(int'(i[24:20]));
        if (f3 == 3'd1 && f7 != 7'd0) bad = 1;
        if (f3 == 3'd5 && i[30]) code = OPC_SRAI;
      end
      7'h33: begin
        code = OP_TAB[f3]; r.op_type = 3'(T_ARITH);
        r.rs1 = i[19:15]; r.rs2 = i[24:20]; r.rd = i[11:7];
        if (f7 == 7'h20 && f3 == 3'd0) code = OPC_SUB;
        else if (f7 == 7'h20 && f3 == 3'd5) code = OPC_SRA;
        else if (f7 != 7'd0) bad = 1;
      end
      default: bad = 1;
    endcase
    r.opcode = 6'(code);
    r.pc = p;
    if (bad) r = mk(T_NOP, OPC_NOP, 0, 0, 0, 32'd0, p, 1'b1);
    return r;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [6:0]  opc;
    r = $urandom();
    case ($urandom_range(0, 9))
      0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;  3: opc = 7'h67;  4: opc = 7'h63;
      5: opc = 7'h03;  6: opc = 7'h23;  7: opc = 7'h13;  8: opc = 7'h33;
      default: opc = r[6:0];
    endcase
    return {r[31:7], opc};
  endfunction

  initial begin
    rec_t empty_r;
    empty_r = '0;

    vt[0]  = '{32'hFFF10093, 32'h100, mk(T_ARITH,  OPC_ADDI, 2, 0, 1, 32'hFFFFFFFF, 32'h100, 1'b0)};
    vt[1]  = '{32'hFE208EE3, 32'h104, mk(T_BRANCH, OPC_BEQ,  1, 2, 0, 32'hFFFFFFFC, 32'h104, 1'b0)};
    vt[2]  = '{32'h4041D193, 32'h108, mk(T_ARITH,  OPC_SRAI, 3, 0, 3, 32'h00000004, 32'h108, 1'b0)};
    vt[3]  = '{32'hFFFFFFFF, 32'h10C, mk(T_NOP,    OPC_NOP,  0, 0, 0, 32'h00000000, 32'h10C, 1'b1)};
    vt[4]  = '{32'h123452B7, 32'h110, mk(T_ARITH,  OPC_LUI,  0, 0, 5, 32'h12345000, 32'h110, 1'b0)};
    vt[5]  = '{32'h0020A423, 32'h114, mk(T_STORE,  OPC_SW,   1, 2, 0, 32'h00000008, 32'h114, 1'b0)};
    vt[6]  = '{32'hFFC0A183, 32'h118, mk(T_LOAD,   OPC_LW,   1, 0, 3, 32'hFFFFFFFC, 32'h118, 1'b0)};
    vt[7]  = '{32'h402081B3, 32'h11C, mk(T_ARITH,  OPC_SUB,  1, 2, 3, 32'h00000000, 32'h11C, 1'b0)};
    vt[8]  = '{32'h008000EF, 32'h120, mk(T_BRANCH, OPC_JAL,  0, 0, 1, 32'h00000008, 32'h120, 1'b0)};
    vt[9]  = '{32'h0000B003, 32'h124, mk(T_NOP,    OPC_NOP,  0, 0, 0, 32'h00000000, 32'h124, 1'b1)};
    vt[10] = '{32'h40109093, 32'h128, mk(T_NOP,    OPC_NOP,  0, 0, 0, 32'h00000000, 32'h128, 1'b1)};
    vt[11] = '{32'h00109093, 32'h12C, mk(T_ARITH,  OPC_SLLI, 1, 0, 1, 32'h00000001, 32'h12C, 1'b0)};

    // Reset state, then an async reset pulse in the middle of a cycle with two entries queued
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_v("reset_ready", 32'(iq_ready), 32'd1);
    chk_v("reset_valid", 32'(dp_valid), 32'd0);
    chk_v("reset_count", 32'(count), 32'd0);
    chk_r("reset_rec", empty_r);
    iq_valid = 1'b1; inst = vt[0].inst; pc = vt[0].pc;
    tick();
    inst = vt[1].inst; pc = vt[1].pc;
    tick();
    iq_valid = 1'b0;
    chk_v("prefill_count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk_v("async_rst_valid", 32'(dp_valid), 32'd0);
    chk_v("async_rst_count", 32'(count), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    chk_v("rst_release_ready", 32'(iq_ready), 32'd1);
    tick();

    // Table: push each vector alone, check the head next cycle, then pop it
    for (int k = 0; k < 12; k++) begin
      iq_valid = 1'b1; inst = vt[k].inst; pc = vt[k].pc; dp_ready = 1'b0;
      tick();
      iq_valid = 1'b0;
      chk_v($sformatf("vec%0d_count", k), 32'(count), 32'd1);
      chk_r($sformatf("vec%0d_rec", k), vt[k].e);
      dp_ready = 1'b1;
      tick();
      dp_ready = 1'b0;
      chk_v($sformatf("vec%0d_drain", k), 32'(dp_valid), 32'd0);
    end

    // Back-to-back beq, srai keep order
    iq_valid = 1'b1; inst = vt[1].inst; pc = vt[1].pc;
    tick();
    inst = vt[2].inst; pc = vt[2].pc;
    tick();
    iq_valid = 1'b0;
    chk_v("pair_full_ready", 32'(iq_ready), 32'd0);
    chk_v("pair_count", 32'(count), 32'd2);
    chk_r("pair_head0", vt[1].e);
    dp_ready = 1'b1;
    tick();
    chk_r("pair_head1", vt[2].e);
    tick();
    dp_ready = 1'b0;

    // Full, then drain while offering new instructions: count holds once push+pop overlap
    iq_valid = 1'b1; inst = vt[4].inst; pc = vt[4].pc;
    tick();
    inst = vt[5].inst; pc = vt[5].pc;
    tick();
    chk_v("full_count", 32'(count), 32'd2);
    chk_v("full_ready", 32'(iq_ready), 32'd0);
    inst = vt[6].inst; pc = vt[6].pc; dp_ready = 1'b1;
    tick();
    chk_v("drain1_count", 32'(count), 32'd1);
    chk_r("drain1_head", vt[5].e);
    tick();
    chk_v("drain2_count", 32'(count), 32'd1);
    chk_r("drain2_head", vt[6].e);
    inst = vt[7].inst; pc = vt[7].pc;
    tick();
    chk_v("drain3_count", 32'(count), 32'd1);
    chk_r("drain3_head", vt[7].e);
    iq_valid = 1'b0;
    tick();
    dp_ready = 1'b0;
    chk_v("drain_empty", 32'(count), 32'd0);

    // Flush a full FIFO while an instruction is offered
    iq_valid = 1'b1; inst = vt[0].inst; pc = vt[0].pc;
    tick(); tick();
    inst = vt[8].inst; pc = vt[8].pc; flush = 1'b1;
    #1;
    chk_v("flush_ready", 32'(iq_ready), 32'd0);
    tick();
    flush = 1'b0; iq_valid = 1'b0;
    chk_v("flush_count", 32'(count), 32'd0);
    chk_v("flush_valid", 32'(dp_valid), 32'd0);
    tick();
    chk_v("flush_not_stored", 32'(count), 32'd0);

    // rdy low freezes everything, including a pending pop, push and flush
    iq_valid = 1'b1; inst = vt[3].inst; pc = vt[3].pc;
    tick();
    inst = vt[11].inst; pc = vt[11].pc; dp_ready = 1'b1; rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) flush = 1'b1;
      tick();
      chk_v($sformatf("frz%0d_count", k), 32'(count), 32'd1);
      chk_r($sformatf("frz%0d_rec", k), vt[3].e);
    end
    flush = 1'b1; rdy = 1'b1; iq_valid = 1'b0; dp_ready = 1'b0;
    tick();
    flush = 1'b0;

    // Randomized traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      bit exp_ready, do_push, do_pop;
      rdy = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 19) == 0);
      iq_valid = $urandom_range(0, 1);
      dp_ready = ($urandom_range(0, 2) != 0);
      inst = gen_inst();
      pc = $urandom();
      #1;
      exp_ready = (model_q.size() != DEPTH) && !flush;
      chk_v("rnd_ready", 32'(iq_ready), 32'(exp_ready));
      chk_v("rnd_valid", 32'(dp_valid), 32'(model_q.size() != 0));
      chk_v("rnd_count", 32'(count), 32'(model_q.size()));
      chk_r("rnd_head", (model_q.size() != 0) ? model_q[0] : empty_r);
      if (rdy) begin
        if (flush) begin
          model_q.delete();
        end else begin
          do_push = iq_valid && exp_ready;
          do_pop  = dp_ready && (model_q.size() != 0);
          if (do_pop) void'(model_q.pop_front());
          if (do_push) model_q.push_back(ref_decode(inst, pc));
        end
      end
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
